mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit.
// The state register advances once per instruction step. The control outputs
// are decoded from the current state and the few live inputs. They are forced
// to zero while reset is held, so that an aborted instruction cannot emit a
// write pulse.
//
// Memory handshake: an access is offered for as long as the FSM sits in FETCH,
// MEMRD or MEMWR. It completes in the first cycle in which mem_ready is 1, and
// the FSM leaves that state on the following edge. mem_ready is ignored in all
// other states.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alusrca,
    output logic       illegal_op,
    output logic [1:0] regdst_sel,
    output logic [1:0] memtoreg_sel,
    output logic [1:0] alusrcb_sel,
    output logic [1:0] pcsrc_sel,
    output logic [1:0] alu_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    state_t state_q;

    assign state = state_q;

    // State register with next-state selection; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:   state_q <= S_MEMADR;
                        OP_RTYPE:       state_q <= S_EXEC;
                        OP_ADDI:        state_q <= S_ADDIEX;
                        OP_BEQ, OP_BNE: state_q <= S_BRANCH;
                        OP_J:           state_q <= S_JUMP;
                        OP_JAL:         state_q <= S_JAL;
                        default:        state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_q <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state_q <= S_FETCH;
                S_MEMWR:  state_q <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   state_q <= (funct == FN_JR) ? S_JR : S_ALUWB;
                S_ALUWB:  state_q <= S_FETCH;
                S_ADDIEX: state_q <= S_ADDIWB;
                S_ADDIWB: state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
                S_JAL:    state_q <= S_FETCH;
                S_JR:     state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Control decode from the current state. Everything idles at zero, and reset overrides all of it.
    always_comb begin
        pc_en        = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        alusrca      = 1'b0;
        illegal_op   = 1'b0;
        regdst_sel   = 2'b00;
        memtoreg_sel = 2'b00;
        alusrcb_sel  = 2'b00;
        pcsrc_sel    = 2'b00;
        alu_op       = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    // PC+4 is written together with the instruction word, only when the fetch completes.
                    mem_read    = 1'b1;
                    alusrcb_sel = 2'b01;
                    ir_write    = mem_ready;
                    pc_en       = mem_ready;
                end
                S_DECODE: begin
                    // Branch target is precomputed here, while the register file is being read.
                    alusrcb_sel = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_ADDI,
                        OP_BEQ, OP_BNE, OP_J, OP_JAL: illegal_op = 1'b0;
                        default:                      illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alusrca     = 1'b1;
                    alusrcb_sel = 2'b10;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    reg_write    = 1'b1;
                    memtoreg_sel = 2'b01;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    alu_op  = 2'b10;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    regdst_sel = 2'b01;
                end
                S_ADDIEX: begin
                    alusrca     = 1'b1;
                    alusrcb_sel = 2'b10;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    // bne takes the branch when the operands differ, so it inverts the zero flag.
                    alusrca   = 1'b1;
                    alu_op    = 2'b01;
                    pcsrc_sel = 2'b01;
                    pc_en     = zero ^ (opcode == OP_BNE);
                end
                S_JUMP: begin
                    pcsrc_sel = 2'b10;
                    pc_en     = 1'b1;
                end
                S_JAL: begin
                    // The link address (PC+4) goes to $31 on the same edge that the PC takes the target.
                    pcsrc_sel    = 2'b10;
                    pc_en        = 1'b1;
                    reg_write    = 1'b1;
                    regdst_sel   = 2'b10;
                    memtoreg_sel = 2'b10;
                end
                S_JR: begin
                    pcsrc_sel = 2'b11;
                    pc_en     = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl. Each instruction is planned as an expected state trace,
// with the mem_ready value to drive in every cycle, plus the effects that the
// instruction should have: write pulses, memory cycles, PC updates and select values.
module tb_mips_mc_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic pc_en, iord, mem_read, mem_write, ir_write, reg_write, alusrca, illegal_op;
  logic [1:0] regdst_sel, memtoreg_sel, alusrcb_sel, pcsrc_sel, alu_op;
  logic [3:0] state;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alusrca(alusrca), .illegal_op(illegal_op), .regdst_sel(regdst_sel),
    .memtoreg_sel(memtoreg_sel), .alusrcb_sel(alusrcb_sel), .pcsrc_sel(pcsrc_sel),
    .alu_op(alu_op), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  wire [17:0] all_outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, alusrca,
                          illegal_op, regdst_sel, memtoreg_sel, alusrcb_sel, pcsrc_sel, alu_op};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ALU setup each step needs: {alusrca, alusrcb_sel, alu_op}
  function automatic logic [4:0] alu_cfg(input logic [3:0] s);
    case (s)
      4'd0:    return 5'b0_01_00;  // PC + 4
      4'd1:    return 5'b0_11_00;  // PC + branch offset
      4'd2:    return 5'b1_10_00;  // rs + imm (address)
      4'd6:    return 5'b1_00_10;  // rs op rt by funct
      4'd8:    return 5'b1_10_00;  // rs + imm
      4'd10:   return 5'b1_00_01;  // rs - rt compare
      default: return 5'b0_00_00;
    endcase
  endfunction

  task automatic push(input logic [3:0] s, input logic r);
    exp_q.push_back(s);
    rdy_q.push_back(r);
  endtask

  // Leave reset: the first cycle with rst low must already look like FETCH.
  task automatic release_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rel_state", state, 4'd0);
    check("rel_memrd", mem_read, 1'b1);
    check("rel_srcb", alusrcb_sel, 2'b01);
    check("rel_irw", {ir_write, pc_en}, 2'b00);
    @(posedge clk); #1;
  endtask

  // Driver plus scoreboard for one instruction. abort_at: -1 none, -2 random, -3 first data-memory step.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm, input int abort_at);
    bit legal, is_lw, is_sw, is_r, is_jr, is_br, taken;
    int e_regw, e_memwr, e_memrd, e_iord, e_pcen, e_ill;
    logic [1:0] e_dst, e_m2r, e_pcsrc;
    int o_regw, o_memwr, o_memrd, o_iord, o_pcen, o_ill, o_irw;
    logic [1:0] o_dst, o_m2r, o_pcsrc;
    int ab;
    exp_q.delete();
    rdy_q.delete();
    is_lw = (op == 6'h23);
    is_sw = (op == 6'h2B);
    is_r  = (op == 6'h00);
    is_jr = is_r && (fn == 6'h08);
    is_br = (op == 6'h04) || (op == 6'h05);
    taken = is_br && (z ^ (op == 6'h05));
    legal = is_lw || is_sw || is_r || is_br || op == 6'h08 || op == 6'h02 || op == 6'h03;

    // Expected state trace.
    for (int k = 0; k < wf; k++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom_range(0, 1)));
    if (is_lw || is_sw) begin
      push(4'd2, 1'($urandom_range(0, 1)));
      for (int k = 0; k < wm; k++) push(is_lw ? 4'd3 : 4'd5, 1'b0);
      push(is_lw ? 4'd3 : 4'd5, 1'b1);
      if (is_lw) push(4'd4, 1'($urandom_range(0, 1)));
    end else if (is_r) begin
      push(4'd6, 1'($urandom_range(0, 1)));
      push(is_jr ? 4'd13 : 4'd7, 1'($urandom_range(0, 1)));
    end else if (op == 6'h08) begin
      push(4'd8, 1'($urandom_range(0, 1)));
      push(4'd9, 1'($urandom_range(0, 1)));
    end else if (is_br) push(4'd10, 1'($urandom_range(0, 1)));
    else if (op == 6'h02) push(4'd11, 1'($urandom_range(0, 1)));
    else if (op == 6'h03) push(4'd12, 1'($urandom_range(0, 1)));

    // Expected effects of the whole instruction.
    e_regw  = (is_lw || (is_r && !is_jr) || op == 6'h08 || op == 6'h03) ? 1 : 0;
    e_dst   = (is_r && !is_jr) ? 2'b01 : (op == 6'h03) ? 2'b10 : 2'b00;
    e_m2r   = is_lw ? 2'b01 : (op == 6'h03) ? 2'b10 : 2'b00;
    e_memwr = is_sw ? wm + 1 : 0;
    e_memrd = wf + 1 + (is_lw ? wm + 1 : 0);
    e_iord  = (is_lw || is_sw) ? wm + 1 : 0;
    e_pcen  = 1 + ((is_jr || op == 6'h02 || op == 6'h03 || taken) ? 1 : 0);
    e_pcsrc = is_jr ? 2'b11 : (op == 6'h02 || op == 6'h03) ? 2'b10 : taken ? 2'b01 : 2'b00;
    e_ill   = legal ? 0 : 1;

    ab = abort_at;
    if (ab == -2) ab = $urandom_range(0, exp_q.size() - 1);
    if (ab == -3) begin
      ab = -1;
      foreach (exp_q[k]) if (ab < 0 && (exp_q[k] == 4'd3 || exp_q[k] == 4'd5)) ab = k;
    end

    opcode = op;
    funct = fn;
    zero = z;
    {o_regw, o_memwr, o_memrd, o_iord, o_pcen, o_ill, o_irw} = '0;
    {o_dst, o_m2r, o_pcsrc} = '0;
    foreach (exp_q[i]) begin
      if (i == ab) begin
        // Reset in the middle of the instruction: everything goes quiet at once.
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("rst_outs_now", all_outs, 18'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", state, 4'd0);
        check("rst_outs", all_outs, 18'd0);
        release_reset();
        return;
      end
      mem_ready = rdy_q[i];
      @(negedge clk);
      check($sformatf("state[%0d] op%0h", i, op), state, exp_q[i]);
      check("alu_cfg", {alusrca, alusrcb_sel, alu_op}, alu_cfg(exp_q[i]));
      check("rd_wr_excl", mem_read & mem_write, 1'b0);
      if (reg_write) begin o_regw++; o_dst = regdst_sel; o_m2r = memtoreg_sel; end
      if (reg_write && op == 6'h03) check("jal_same_cycle", pc_en, 1'b1);
      if (pc_en) begin o_pcen++; o_pcsrc = pcsrc_sel; end
      if (mem_write) o_memwr++;
      if (mem_read) o_memrd++;
      if (iord) o_iord++;
      if (illegal_op) o_ill++;
      if (ir_write) o_irw++;
      @(posedge clk); #1;
    end
    check("ret_fetch", state, 4'd0);
    check("n_regw", o_regw, e_regw);
    if (e_regw > 0) check("wb_sel", {o_dst, o_m2r}, {e_dst, e_m2r});
    check("n_memwr", o_memwr, e_memwr);
    check("n_memrd", o_memrd, e_memrd);
    check("n_iord", o_iord, e_iord);
    check("n_pcen", o_pcen, e_pcen);
    check("last_pcsrc", o_pcsrc, e_pcsrc);
    check("n_illegal", o_ill, e_ill);
    check("n_irw", o_irw, 1);
  endtask

  logic [5:0] legal_ops[8] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h05, 6'h02, 6'h03};

  initial begin
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_state", state, 4'd0);
    check("reset_outs", all_outs, 18'd0);
    release_reset();

    // Directed cases.
    run_instr(6'h23, 6'h00, 1'b0, 0, 0, -1);  // lw
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, -1);  // add
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, -1);  // jr
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1);  // beq taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, -1);  // bne not taken
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, -1);  // bne taken
    run_instr(6'h2B, 6'h00, 1'b0, 0, 3, -1);  // sw with 3 wait cycles
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1);  // illegal
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, -1);  // jal
    run_instr(6'h08, 6'h00, 1'b0, 2, 0, -1);  // addi, slow fetch
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);  // j
    run_instr(6'h23, 6'h00, 1'b0, 0, 2, -3);  // reset in MEMRD
    run_instr(6'h2B, 6'h00, 1'b0, 0, 3, -3);  // reset during MEMWR wait
    run_instr(6'h23, 6'h00, 1'b0, 1, 1, -1);  // clean instruction after the abort

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      int sel;
      logic [5:0] op, fn;
      sel = $urandom_range(0, 9);
      fn = 6'($urandom);
      if (sel < 8) op = legal_ops[sel];
      else if (sel == 8) begin op = 6'h00; fn = 6'h08; end
      else begin
        op = 6'($urandom);
        foreach (legal_ops[k]) if (op == legal_ops[k]) op = 6'h3F;
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 11) == 0) ? -2 : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
